// File: rtl/vc_sync_fifo.sv
// rtl/vc_sync_fifo.sv - single-clock multi-virtual-channel FIFO over one shared storage array
// Optional sticky overflow/underflow capture is built when FIFO_ERRCHK_EN is defined.
module vc_sync_fifo #(
  parameter int DSIZE     = 32,
  parameter int ADDRSIZE  = 3,
  parameter int NUM_VC    = 2,
  parameter int VCW       = 1,
  parameter int AFULL_LVL = (1 << ADDRSIZE) - 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DSIZE-1:0]                 wdata,
  input  logic                             winc,
  input  logic [VCW-1:0]                   wvc,
  input  logic                             rinc,
  input  logic [VCW-1:0]                   rvc,
  output logic [DSIZE-1:0]                 rdata,
  output logic [NUM_VC-1:0]                wfull,
  output logic [NUM_VC-1:0]                walmost_full,
  output logic [NUM_VC-1:0]                rempty,
  output logic [NUM_VC*(ADDRSIZE+1)-1:0]   count,
  output logic [NUM_VC-1:0]                err_ovf,
  output logic [NUM_VC-1:0]                err_udf
);

  localparam int PW   = ADDRSIZE + 1;
  localparam int MEMD = (1 << VCW) * (1 << ADDRSIZE);
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_LVL);

  logic [PW-1:0]    wptr_q [NUM_VC];
  logic [PW-1:0]    wptr_d [NUM_VC];
  logic [PW-1:0]    rptr_q [NUM_VC];
  logic [PW-1:0]    rptr_d [NUM_VC];
  logic [PW-1:0]    occ    [NUM_VC];
  logic [DSIZE-1:0] mem    [MEMD];

  logic [PW-1:0] wptr_sel, rptr_sel;
  logic          wvc_ok, rvc_ok, wfull_sel, rempty_sel;
  logic          wr_en, rd_en;

  always_comb begin
    count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occ[v]          = wptr_q[v] - rptr_q[v];
      rempty[v]       = (wptr_q[v] == rptr_q[v]);
      wfull[v]        = ({~wptr_q[v][ADDRSIZE], wptr_q[v][ADDRSIZE-1:0]} == rptr_q[v]);
      walmost_full[v] = (occ[v] >= AFULL_V);
      count[v*PW +: PW] = occ[v];
    end
  end

  // Channel selects outside 0..NUM_VC-1 match no channel, so their requests are dropped.
  always_comb begin
    wptr_sel   = '0;
    rptr_sel   = '0;
    wvc_ok     = 1'b0;
    rvc_ok     = 1'b0;
    wfull_sel  = 1'b1;
    rempty_sel = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wvc == VCW'(v)) begin
        wptr_sel  = wptr_q[v];
        wfull_sel = wfull[v];
        wvc_ok    = 1'b1;
      end
      if (rvc == VCW'(v)) begin
        rptr_sel   = rptr_q[v];
        rempty_sel = rempty[v];
        rvc_ok     = 1'b1;
      end
    end
  end

  assign wr_en = winc && wvc_ok && !wfull_sel;
  assign rd_en = rinc && rvc_ok && !rempty_sel;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wptr_d[v] = wptr_q[v] + {{(PW-1){1'b0}}, (wr_en && (wvc == VCW'(v)))};
      rptr_d[v] = rptr_q[v] + {{(PW-1){1'b0}}, (rd_en && (rvc == VCW'(v)))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= wptr_d[v];
        rptr_q[v] <= rptr_d[v];
      end
    end
  end

  // Storage keeps no reset so it can map onto RAM; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wvc, wptr_sel[ADDRSIZE-1:0]}] <= wdata;
  end

  assign rdata = mem[{rvc, rptr_sel[ADDRSIZE-1:0]}];

`ifdef FIFO_ERRCHK_EN
  logic [NUM_VC-1:0] err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (winc && (wvc == VCW'(v)) && wfull[v])  err_ovf_d[v] = 1'b1;
      if (rinc && (rvc == VCW'(v)) && rempty[v]) err_udf_d[v] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= '0;
      err_udf_q <= '0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = '0;
  assign err_udf = '0;
`endif

endmodule

// File: tb/tb_vc_sync_fifo.sv
// tb/tb_vc_sync_fifo.sv - scoreboard bench for vc_sync_fifo against per-channel queue model
module tb_vc_sync_fifo;
  localparam int DSIZE = 32, ADDRSIZE = 3, NUM_VC = 2, VCW = 1;
  localparam int DEPTH = 8, AFL = 6, PW = ADDRSIZE + 1;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [DSIZE-1:0]            wdata = '0;
  logic                        winc = 1'b0;
  logic [VCW-1:0]              wvc = '0;
  logic                        rinc = 1'b0;
  logic [VCW-1:0]              rvc = '0;
  logic [DSIZE-1:0]            rdata;
  logic [NUM_VC-1:0]           wfull, walmost_full, rempty, err_ovf, err_udf;
  logic [NUM_VC*PW-1:0]        count;

  vc_sync_fifo #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .NUM_VC(NUM_VC), .VCW(VCW), .AFULL_LVL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wvc(wvc), .rinc(rinc), .rvc(rvc),
    .rdata(rdata), .wfull(wfull), .walmost_full(walmost_full), .rempty(rempty), .count(count),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DSIZE-1:0] mq [NUM_VC][$];
  logic [DSIZE-1:0] exp_q [$];
  bit m_ovf [NUM_VC];
  bit m_udf [NUM_VC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    for (int v = 0; v < NUM_VC; v++) begin
      chk($sformatf("count%0d", v), 64'(count[v*PW +: PW]), 64'(mq[v].size()));
      chk($sformatf("rempty%0d", v), 64'(rempty[v]), 64'(mq[v].size() == 0));
      chk($sformatf("wfull%0d", v), 64'(wfull[v]), 64'(mq[v].size() == DEPTH));
      chk($sformatf("afull%0d", v), 64'(walmost_full[v]), 64'(mq[v].size() >= AFL));
`ifdef FIFO_ERRCHK_EN
      chk($sformatf("err_ovf%0d", v), 64'(err_ovf[v]), 64'(m_ovf[v]));
      chk($sformatf("err_udf%0d", v), 64'(err_udf[v]), 64'(m_udf[v]));
`else
      chk($sformatf("err_ovf%0d", v), 64'(err_ovf[v]), 64'(0));
      chk($sformatf("err_udf%0d", v), 64'(err_udf[v]), 64'(0));
`endif
    end
    if (mq[int'(rvc)].size() > 0) chk("rdata_head", 64'(rdata), 64'(mq[int'(rvc)][0]));
  endtask

  task automatic step(input bit w, input int wv, input logic [DSIZE-1:0] wd, input bit r, input int rv);
    bit wacc, racc;
    wacc = w && (mq[wv].size() < DEPTH);
    racc = r && (mq[rv].size() > 0);
    if (w && !wacc) m_ovf[wv] = 1'b1;
    if (r && !racc) m_udf[rv] = 1'b1;
    if (racc) exp_q.push_back(mq[rv][0]);
    winc = w; wvc = VCW'(wv); wdata = wd; rinc = r; rvc = VCW'(rv);
    @(posedge clk);
    if (racc) void'(mq[rv].pop_front());
    if (wacc) mq[wv].push_back(wd);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    check_state();
  endtask

  // Monitor: every read the DUT presents as accepted consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && rinc && !rempty[rvc]) begin
      if (exp_q.size() == 0) chk("unexpected_read", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("read_data", 64'(rdata), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_state();

    for (int i = 1; i <= 8; i++) step(1, 0, DSIZE'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);

    for (int i = 1; i <= 8; i++) step(1, 1, DSIZE'(32'h100 + i), 0, 1);
    step(1, 1, 32'hDEAD, 0, 1);
    step(0, 1, '0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 1, 1);

    step(1, 0, 32'hA, 0, 0);
    step(1, 1, 32'hB, 0, 0);
    step(1, 0, 32'hC, 0, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);

    for (int i = 1; i <= 8; i++) step(1, 0, DSIZE'(32'h10 + i), 0, 0);
    step(1, 0, 32'h99, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, '0, 1, 0);
    step(1, 0, 32'h55, 1, 0);
    step(0, 0, '0, 1, 0);

    step(1, 0, 32'd1000, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, 0, DSIZE'(1000 + i), 1, 0);
    step(0, 0, '0, 1, 0);

    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 99) < 55), int'($urandom_range(0, 1)), DSIZE'($urandom),
           bit'($urandom_range(0, 99) < 45), int'($urandom_range(0, 1)));

    step(1, 0, 32'h77, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_count0", 64'(count[PW-1:0]), 64'(0));
    chk("reset_rempty0", 64'(rempty[0]), 64'(1));
    for (int v = 0; v < NUM_VC; v++) begin
      mq[v].delete();
      m_ovf[v] = 1'b0;
      m_udf[v] = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_state();
    step(1, 1, 32'h1234, 0, 1);
    step(0, 1, '0, 1, 1);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_sync_fifo.md
# vc_sync_fifo

Single-clock, multi-virtual-channel FIFO for router input ports: NUM_VC independent FIFOs of 2^ADDRSIZE words each, held in one shared storage array and addressed as {vc, pointer}. It replaces per-channel instances of the dual-clock FIFO wherever producer and consumer share a clock. It adds per-channel occupancy counts, almost-full flags for credit back-pressure, and optional overflow/underflow error capture.

## Interface
- DSIZE, 32, data word width
- ADDRSIZE, 3, log2 of per-channel depth (DEPTH = 2^ADDRSIZE)
- NUM_VC, 2, number of virtual channels (≥1)
- VCW, 1, width of channel-select ports (2^VCW ≥ NUM_VC)
- AFULL_LVL, 2^ADDRSIZE-2, occupancy at or above which walmost_full[v] asserts (1..DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wdata  in  DSIZE  write word
- winc  in  1  write request
- wvc  in  VCW  write channel select
- rinc  in  1  read request
- rvc  in  VCW  read channel select
- rdata  out  DSIZE  head word of channel rvc (show-ahead)
- wfull  out  NUM_VC  per-channel full
- walmost_full  out  NUM_VC  per-channel count ≥ AFULL_LVL
- rempty  out  NUM_VC  per-channel empty
- count  out  NUM_VC*(ADDRSIZE+1)  per-channel occupancy; channel v at bits [v*(ADDRSIZE+1) +: ADDRSIZE+1]
- err_ovf  out  NUM_VC  sticky: write attempted while full
- err_udf  out  NUM_VC  sticky: read attempted while empty

## Operation
- Per channel: wptr, rptr, each ADDRSIZE+1 bits binary; memory index = {vc, ptr[ADDRSIZE-1:0]}.
- count[v] = wptr[v] − rptr[v] modulo 2^(ADDRSIZE+1), range 0..DEPTH.
- rempty[v] = (wptr == rptr); wfull[v] = (MSBs differ, lower ADDRSIZE bits equal).
- Write accepted iff winc && !wfull[wvc]: mem[{wvc, wptr}] ← wdata, wptr[wvc] increments.
- Read accepted iff rinc && !rempty[rvc]: rptr[rvc] increments; the word presented on rdata that cycle is consumed.
- Rejected requests leave all state unchanged.
- Flags and count are evaluated from the pre-edge pointers: a write to a full channel is rejected even if the same channel is read that cycle; a read of an empty channel is rejected even if the same channel is written that cycle.
- Same-channel write and read both accepted: count unchanged; both pointers advance.
- Different-channel write and read are independent.
- wvc/rvc ≥ NUM_VC: request ignored; rdata undefined.
- Pointer wrap: the MSB toggles every DEPTH operations, and the lower bits wrap to 0 with no gap.
- Storage array is not reset.

## Timing
- Reset (async assert, sync-release use assumed by system): all pointers 0, rempty all 1, wfull 0, walmost_full 0 (AFULL_LVL ≥ 1), count 0, err_ovf/err_udf 0. rdata is undefined until the first write.
- Write-to-read latency: the word is visible on rdata and rempty deasserts in the cycle after the accepting edge.
- rdata is combinational from the registered rptr[rvc] and the array; rvc changes reflect in the same cycle.
- All flags and counts are combinational functions of registered pointers; they change only after a clock edge or reset.
- Reset asserted mid-operation: pointers clear immediately, and buffered data is discarded.

## Configuration
- FIFO_ERRCHK_EN defined: err_ovf[v] sets on the edge of a rejected write to full channel v; err_udf[v] sets on the edge of a rejected read from empty channel v. Both are sticky until reset.
- Not defined: err_ovf and err_udf are tied to 0 and no error registers are built. Data path and flags are unchanged.

## Test plan
- Reset then idle: rempty=all 1, wfull=0, count=0, err=0. Rising clk with no requests keeps the same values.
- ADDRSIZE=3, VC0: write 0x1..0x8. After the 6th write walmost_full[0]=1; after the 8th write wfull[0]=1 and count0=8. Read 8: rdata sequence 0x1..0x8, then rempty[0]=1.
- Fill VC1 with 8 words, then write 0xDEAD to VC1: word dropped, count1 stays 8. With FIFO_ERRCHK_EN, err_ovf[1]=1 next cycle.
- Interleaved: write VC0=0xA, VC1=0xB, VC0=0xC. Read rvc=1 → 0xB; read rvc=0 → 0xA, then 0xC. Channels do not interfere.
- Full VC0, same-cycle write 0x99 and read: read returns the head word, write rejected, count0=7. Empty VC0, same-cycle write 0x55 and read: read rejected, count0=1, rdata=0x55 next cycle.
- 20 write/read pairs through VC0 (pointer wraps twice): data order preserved. Assert rst_n low mid-stream: count0=0 and rempty[0]=1 immediately.
